// File: rtl/adpll_regs.sv
// CPU register responder for the ADPLL: holds enable/mode/FCW/gain configuration
// and tracks lock status with sticky flags and a saturating lock-loss counter.
module adpll_regs #(
    parameter int unsigned ADPLL_ADDR_W = 5,
    parameter logic [31:0] ID_VALUE     = 32'hADB1_0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel,
    input  logic                    write,
    input  logic [ADPLL_ADDR_W-1:0] address,
    input  logic [31:0]             data_in,
    output logic [31:0]             data_out,
    output logic                    ready,
    input  logic                    channel_lock,
    output logic                    cfg_en,
    output logic [1:0]              cfg_mode,
    output logic [25:0]             cfg_fcw,
    output logic [3:0]              cfg_alpha_l,
    output logic [3:0]              cfg_alpha_m,
    output logic [3:0]              cfg_alpha_s,
    output logic [3:0]              cfg_beta,
    output logic                    soft_rst
);

    localparam int unsigned FCW_W = 26;
    localparam int unsigned CNT_W = 8;

    localparam logic [ADPLL_ADDR_W-1:0] A_CTRL   = ADPLL_ADDR_W'(0);
    localparam logic [ADPLL_ADDR_W-1:0] A_SHADOW = ADPLL_ADDR_W'(1);
    localparam logic [ADPLL_ADDR_W-1:0] A_APPLY  = ADPLL_ADDR_W'(2);
    localparam logic [ADPLL_ADDR_W-1:0] A_STATUS = ADPLL_ADDR_W'(3);
    localparam logic [ADPLL_ADDR_W-1:0] A_GAIN   = ADPLL_ADDR_W'(4);
    localparam logic [ADPLL_ADDR_W-1:0] A_ACTIVE = ADPLL_ADDR_W'(5);
    localparam logic [ADPLL_ADDR_W-1:0] A_ID     = ADPLL_ADDR_W'(6);

    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    state_t             state_q;
    logic               ready_q;
    logic [31:0]        rdata_q;
    logic               soft_q;
    logic               en_q;
    logic [1:0]         mode_q;
    logic [FCW_W-1:0]   shadow_q;
    logic [FCW_W-1:0]   fcw_q;
    logic [3:0]         al_q, am_q, as_q, beta_q;
    logic               lock_q;
    logic               seen_q, seen_d;
    logic               lost_q, lost_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
    logic [31:0]        rdata_d;

    logic req_c, wr_c, rd_c, soft_c, rise_c, fall_c, clr_c;
    logic wr_ctrl_c, wr_shadow_c, wr_apply_c, wr_status_c, wr_gain_c;
    logic unused_c;

    assign unused_c = ^data_in[31:26];

    // Request decode, lock-event detection and read-data selection
    always_comb begin
        req_c       = (state_q == ST_IDLE) && sel;
        wr_c        = req_c && write;
        rd_c        = req_c && !write;
        wr_ctrl_c   = wr_c && (address == A_CTRL);
        wr_shadow_c = wr_c && (address == A_SHADOW);
        wr_apply_c  = wr_c && (address == A_APPLY);
        wr_status_c = wr_c && (address == A_STATUS);
        wr_gain_c   = wr_c && (address == A_GAIN);
        soft_c      = wr_ctrl_c && data_in[3];
        rise_c      = channel_lock && !lock_q;
        fall_c      = !channel_lock && lock_q && en_q;
        clr_c       = wr_status_c && data_in[2];

        // set events win over write-1-to-clear
        seen_d   = rise_c || (seen_q && !(wr_status_c && data_in[1]));
        lost_d   = fall_c || (lost_q && !clr_c);
        cnt_base = clr_c ? '0 : cnt_q;
        cnt_d    = (fall_c && (cnt_base != {CNT_W{1'b1}})) ? cnt_base + CNT_W'(1) : cnt_base;
        if (soft_c) begin
            seen_d = 1'b0;
            lost_d = 1'b0;
            cnt_d  = '0;
        end

        // status reads reflect events landing on this same edge
        rdata_d = '0;
        case (address)
            A_CTRL:   rdata_d = {29'd0, mode_q, en_q};
            A_SHADOW: rdata_d = {6'd0, shadow_q};
            A_STATUS: rdata_d = {16'd0, cnt_d, 5'd0, lost_d, seen_d, channel_lock};
            A_GAIN:   rdata_d = {16'd0, beta_q, as_q, am_q, al_q};
            A_ACTIVE: rdata_d = {6'd0, fcw_q};
            A_ID:     rdata_d = ID_VALUE;
            default:  rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            soft_q   <= 1'b0;
            en_q     <= 1'b0;
            mode_q   <= '0;
            shadow_q <= '0;
            fcw_q    <= '0;
            al_q     <= 4'd8;
            am_q     <= 4'd6;
            as_q     <= 4'd4;
            beta_q   <= 4'd2;
            lock_q   <= 1'b0;
            seen_q   <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            lock_q <= channel_lock;
            seen_q <= seen_d;
            lost_q <= lost_d;
            cnt_q  <= cnt_d;

            case (state_q)
                ST_IDLE: begin
                    ready_q <= sel;
                    soft_q  <= soft_c;
                    if (sel) begin
                        state_q <= ST_RESP;
                    end
                    if (rd_c) begin
                        rdata_q <= rdata_d;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    soft_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase

            if (wr_ctrl_c) begin
                if (data_in[3]) begin
                    en_q <= 1'b0;
                end else begin
                    en_q   <= data_in[0];
                    mode_q <= data_in[2:1];
                end
            end
            if (wr_shadow_c) shadow_q <= data_in[FCW_W-1:0];
            if (wr_apply_c)  fcw_q    <= shadow_q;
            if (wr_gain_c) begin
                al_q   <= data_in[3:0];
                am_q   <= data_in[7:4];
                as_q   <= data_in[11:8];
                beta_q <= data_in[15:12];
            end
        end
    end

    assign data_out    = rdata_q;
    assign ready       = ready_q;
    assign soft_rst    = soft_q;
    assign cfg_en      = en_q;
    assign cfg_mode    = mode_q;
    assign cfg_fcw     = fcw_q;
    assign cfg_alpha_l = al_q;
    assign cfg_alpha_m = am_q;
    assign cfg_alpha_s = as_q;
    assign cfg_beta    = beta_q;

endmodule
